ks_program_memory: RTL and testbench
====================================

// Module: ks_program_memory
// PURPOSE
//  Word-addressed program/data RAM that serves as the responder for the K&S datapath memory port.
//  After reset it zero-fills itself, then accepts a program image over a valid/ready load stream.
//  It then releases the core from reset and serves core reads and writes.
//  It sits between the testbench/host loader and the datapath's address, write-data and read-data nets.
// PARAMETERS
//  ADDR_W  5   address width; matches the datapath's 5-bit memory address
//  DATA_W  16  word width; matches the datapath's 16-bit instruction/data bus
//  DEPTH   32  number of words; must equal 2**ADDR_W
// PORTS
//  clk          in   1       clock; all state changes on its rising edge
//  rst          in   1       synchronous, active-high reset
//  cpu_addr     in   ADDR_W  core memory address (datapath ram_addr)
//  cpu_wdata    in   DATA_W  core write data (datapath data_out)
//  cpu_write    in   1       core write strobe, from the control unit
//  cpu_rdata    out  DATA_W  read data to the core (datapath data_in)
//  load_valid   in   1       loader word valid
//  load_data    in   DATA_W  loader word
//  load_last    in   1       marks the final image word; qualified by load_valid
//  load_ready   out  1       memory accepts a loader word this cycle
//  load_count   out  ADDR_W+1  number of words accepted since reset (0..DEPTH)
//  load_trunc   out  1       sticky: image filled DEPTH words without load_last
//  cpu_rst_n    out  1       active-low reset to the core; 0 until the image is loaded
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): state goes to CLEAR and clr_ptr=0.
//    load_count=0, load_trunc=0, cpu_rst_n=0, load_ready=0.
//    Reset asserted in any state, mid-load or mid-run, restarts from CLEAR.
//  FSM states are CLEAR, LOAD and RUN.
//  CLEAR: writes 0 to mem[clr_ptr] every cycle and increments clr_ptr.
//    After the write to DEPTH-1, it goes to LOAD. Exactly DEPTH cycles.
//    load_ready=0; cpu_write is ignored.
//  LOAD: load_ready=1 (combinational on state).
//    An accept is a cycle with load_valid & load_ready; mem[load_count] <= load_data and load_count++.
//    If an accept has load_last=1, go to RUN.
//    If an accept fills word DEPTH-1 with load_last=0, go to RUN and set load_trunc=1.
//    Idle cycles with load_valid=0 hold all state. cpu_write is ignored.
//  RUN: load_ready=0. Loader inputs are ignored, and extra words are never written.
//  cpu_rst_n is registered: it is 1 exactly when state==RUN, so it rises on the first RUN cycle.
//  cpu_rdata
//    RUN: asynchronous read, mem[cpu_addr].
//    CLEAR/LOAD: cpu_rdata=0.
//    Zero read latency, because the datapath captures data_in in the same cycle as the address.
//  Core write: in RUN, cpu_write=1 at an edge writes mem[cpu_addr] <= cpu_wdata.
//    A same-cycle read returns the old word; the new word is visible from the next cycle.
//  Width rules: addresses wrap naturally at ADDR_W bits.
//    load_count saturates at DEPTH and never wraps.
//  Memory is single-ported. CLEAR, LOAD and RUN writes are mutually exclusive by state, so no write arbitration is needed.
// TESTING
//  T1 CLEAR timing: deassert rst. Required: load_ready=0 for 32 cycles and 1 on cycle 33; cpu_rst_n=0 throughout.
//  T2 Short load: send 0x8101, 0x8202, 0xFFFF with last on word 3.
//    Required: load_count=3 and cpu_rst_n=1 on the next cycle.
//    Required reads: cpu_addr=1 -> 0x8202; cpu_addr=5 -> 0x0000.
//  T3 Gaps: hold load_valid=1 during CLEAR, then toggle valid in LOAD.
//    Required: no word is written during CLEAR, and only valid cycles advance load_count.
//  T4 Overlong stream: 33 words with no last.
//    Required: 32 accepted and load_trunc=1; load_ready=0 after the 32nd word; word 33 is never written.
//  T5 Run write: in RUN, write addr 0x1F with 0xA5A5.
//    Required: same-cycle rdata is the old value, and next-cycle rdata=0xA5A5.
//    Required: cpu_write during LOAD has no effect.
//  T6 Mid-load reset: assert rst after 2 accepted words, then load 1 word with last.
//    Required: cpu_rst_n drops the cycle after rst; load_count=1; addr 1 reads 0x0000.

Source files
------------

// File: rtl/ks_program_memory.sv
// Program/data RAM for the K&S core: zero-fill, then image load over valid/ready, then core access.
// Zero-latency core reads; load_ready is high only while loading, so the loader stalls during clear and run.
module ks_program_memory #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    output logic              load_trunc,
    output logic              cpu_rst_n
);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    logic [DATA_W-1:0] mem [DEPTH];

    assign load_ready = (state == LOAD);
    assign cpu_rdata  = (state == RUN) ? mem[cpu_addr] : '0;

    // One write port; the state alone picks which source owns it.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdat  = '0;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                if (clr_ptr == LAST_PTR) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    accept    = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = load_count[ADDR_W-1:0];
                    mem_wdat  = load_data;
                    if (load_last || (load_count == LAST_CNT)) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cpu_write) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdat  = cpu_wdata;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            load_count <= '0;
            load_trunc <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_rst_n <= (state_nxt == RUN);
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
            if (accept) begin
                load_count <= load_count + 1'b1;
                if (!load_last && (load_count == LAST_CNT)) begin
                    load_trunc <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

endmodule

// File: tb/tb_ks_program_memory.sv
// Directed bench for ks_program_memory: stimulus queues expectations, a negedge monitor checks them.
module tb_ks_program_memory;

    localparam int K_READY = 0;
    localparam int K_RSTN  = 1;
    localparam int K_COUNT = 2;
    localparam int K_TRUNC = 3;
    localparam int K_RDATA = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_write = 1'b0;
    logic [15:0] cpu_rdata;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic [5:0]  load_count;
    logic        load_trunc;
    logic        cpu_rst_n;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    ks_program_memory #(.ADDR_W(5), .DATA_W(16), .DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .load_trunc (load_trunc),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_READY: observe = {31'd0, load_ready};
            K_RSTN:  observe = {31'd0, cpu_rst_n};
            K_COUNT: observe = {26'd0, load_count};
            K_TRUNC: observe = {31'd0, load_trunc};
            default: observe = {16'd0, cpu_rdata};
        endcase
    endfunction

    // Monitor: pops every expectation tagged with the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            act = observe(e.kind);
            tests++;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: stale expectation (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                fails++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic expect_now(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_read(input logic [4:0] a, input logic [15:0] v, input string name);
        cpu_addr = a;
        expect_now(K_RDATA, {16'd0, v}, name);
        tick();
    endtask

    // Reset, then step through the 32 clear cycles; returns in the first LOAD cycle.
    task automatic reset_and_clear();
        rst = 1'b1;
        load_valid = 1'b0;
        load_last = 1'b0;
        cpu_write = 1'b0;
        tick();
        rst = 1'b0;
        repeat (32) tick();
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        expect_now(K_READY, 0, "rst_ready");
        expect_now(K_RSTN,  0, "rst_cpu_rst_n");
        expect_now(K_COUNT, 0, "rst_count");
        expect_now(K_TRUNC, 0, "rst_trunc");
        expect_now(K_RDATA, 0, "rst_rdata");

        // T1 + T3: valid held high through CLEAR must not be taken
        load_valid = 1'b1;
        load_data  = 16'h1111;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            expect_now(K_READY, 0, $sformatf("clr_ready_%0d", i));
            expect_now(K_RSTN,  0, $sformatf("clr_rstn_%0d", i));
            if (i == 31) expect_now(K_COUNT, 0, "clr_count");
            tick();
        end
        expect_now(K_READY, 1, "load_ready_cyc33");
        expect_now(K_COUNT, 0, "load_count_start");
        tick();
        load_valid = 1'b0;
        cpu_write = 1'b1;
        cpu_addr  = 5'd5;
        cpu_wdata = 16'hBEEF;
        expect_now(K_COUNT, 1, "gap_count_1");
        tick();
        cpu_write = 1'b0;
        expect_now(K_COUNT, 1, "gap_hold_1");
        send(16'h2222, 1'b0);
        expect_now(K_COUNT, 2, "gap_count_2");
        tick();
        expect_now(K_COUNT, 2, "gap_hold_2");
        send(16'h3333, 1'b1);
        expect_now(K_COUNT, 3, "gap_count_3");
        expect_now(K_RSTN,  1, "gap_run");
        expect_read(5'd0, 16'h1111, "gap_rd0");
        expect_read(5'd2, 16'h3333, "gap_rd2");
        expect_read(5'd3, 16'h0000, "gap_rd3");
        expect_read(5'd5, 16'h0000, "load_write_ignored");

        // T2: short load
        reset_and_clear();
        expect_now(K_READY, 1, "t2_ready");
        send(16'h8101, 1'b0);
        send(16'h8202, 1'b0);
        send(16'hFFFF, 1'b1);
        expect_now(K_COUNT, 3, "t2_count");
        expect_now(K_RSTN,  1, "t2_cpu_rst_n");
        expect_now(K_READY, 0, "t2_ready_run");
        expect_now(K_TRUNC, 0, "t2_trunc");
        expect_read(5'd1, 16'h8202, "t2_rd1");
        expect_read(5'd5, 16'h0000, "t2_rd5");
        expect_read(5'd2, 16'hFFFF, "t2_rd2");

        // T5: run write, old value same cycle, new value next cycle
        cpu_addr  = 5'h1F;
        cpu_wdata = 16'hA5A5;
        cpu_write = 1'b1;
        expect_now(K_RDATA, 0, "t5_old");
        tick();
        cpu_write = 1'b0;
        expect_now(K_RDATA, 16'hA5A5, "t5_new");
        tick();

        // T6: reset from RUN drops cpu_rst_n after the edge, then mid-load reset
        rst = 1'b1;
        expect_now(K_RSTN, 1, "t6_rstn_before");
        tick();
        expect_now(K_RSTN, 0, "t6_rstn_after");
        rst = 1'b0;
        repeat (32) tick();
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        expect_now(K_COUNT, 2, "t6_count_2");
        reset_and_clear();
        send(16'h7777, 1'b1);
        expect_now(K_COUNT, 1, "t6_count_1");
        expect_now(K_RSTN,  1, "t6_run");
        expect_read(5'd1, 16'h0000, "t6_rd1");
        expect_read(5'd0, 16'h7777, "t6_rd0");

        // T4: overlong stream truncates at 32 words
        reset_and_clear();
        for (int i = 0; i < 32; i++) begin
            if (i == 31) expect_now(K_TRUNC, 0, "t4_trunc_pre");
            send(16'h4000 + 16'(i), 1'b0);
        end
        expect_now(K_COUNT, 32, "t4_count");
        expect_now(K_TRUNC, 1,  "t4_trunc");
        expect_now(K_READY, 0,  "t4_ready");
        expect_now(K_RSTN,  1,  "t4_run");
        send(16'h4020, 1'b0);
        expect_now(K_COUNT, 32, "t4_count_sat");
        expect_read(5'd0,  16'h4000, "t4_rd0");
        expect_read(5'd31, 16'h401F, "t4_rd31");

        tick();
        tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: never checked, expected 0x%0h", e.name, e.val);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
